// File: rtl/mux4_rr_arbiter_pkg.sv
// Shared state type, sizing constants and the round-robin pick helper for mux4_rr_arbiter.
package arb_pkg;

   typedef enum logic {ARB_IDLE, ARB_GRANT} arb_state_t;

   localparam int NREQ = 4;
   localparam int SELW = 2;

   // Returns {found, idx}: first requester at or after ptr (mod NREQ) that is not masked by excl.
   function automatic logic [SELW:0] rr_pick(input logic [NREQ-1:0] req,
                                             input logic [SELW-1:0] ptr,
                                             input logic [NREQ-1:0] excl);
      logic [SELW:0]   result;
      logic [SELW-1:0] idx;
      result = '0;
      for (int i = 0; i < NREQ; i++) begin
         idx = ptr + SELW'(i);
         if (!result[SELW] && req[idx] && !excl[idx]) begin
            result = {1'b1, idx};
         end
      end
      return result;
   endfunction

endpackage

// File: rtl/mux4_rr_arbiter_if.sv
// Requester-side bus of the four-way round-robin arbiter; requesters use master, the arbiter uses slave.
interface mux4_rr_arbiter_if #(parameter int WIDTH = 32);

   logic [3:0]       req;
   logic [3:0]       done;
   logic [WIDTH-1:0] d0;
   logic [WIDTH-1:0] d1;
   logic [WIDTH-1:0] d2;
   logic [WIDTH-1:0] d3;
   logic [3:0]       gnt;
   logic [1:0]       sel;
   logic             out_valid;
   logic [WIDTH-1:0] out_data;
   logic             busy;
   logic             timeout;

   modport master (
      output req, done, d0, d1, d2, d3,
      input  gnt, sel, out_valid, out_data, busy, timeout
   );

   modport slave (
      input  req, done, d0, d1, d2, d3,
      output gnt, sel, out_valid, out_data, busy, timeout
   );

endinterface

// File: rtl/mux4_rr_arbiter_mux.sv
// yMux4to1: purely combinational 4:1 data selector shared by the arbitrated requesters.
module yMux4to1 #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] d0_i,
   input  logic [WIDTH-1:0] d1_i,
   input  logic [WIDTH-1:0] d2_i,
   input  logic [WIDTH-1:0] d3_i,
   input  logic [1:0]       sel_i,
   output logic [WIDTH-1:0] z_o
);

   always_comb begin
      case (sel_i)
         2'd0:    z_o = d0_i;
         2'd1:    z_o = d1_i;
         2'd2:    z_o = d2_i;
         default: z_o = d3_i;
      endcase
   end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter sharing one yMux4to1 datapath among four requesters.
// Optional grant watchdog enabled by defining ARB_TIMEOUT_EN (limit set by MAX_HOLD).
module mux4_rr_arbiter
   import arb_pkg::*;
#(
   parameter int WIDTH    = 32,
   parameter int MAX_HOLD = 16
) (
   input logic                clk,
   input logic                rst,
   mux4_rr_arbiter_if.slave   bus
);

   arb_state_t       state_q;
   logic [NREQ-1:0]  gnt_q;
   logic [SELW-1:0]  sel_q;
   logic [SELW-1:0]  ptr_q;
   logic [SELW-1:0]  ptr_d;
   logic [NREQ-1:0]  arbExcl;
   logic [SELW:0]    pick;
   logic             normalEnd;
   logic             holdExpired;
   logic             grantEnd;
   logic             newGrant;
   logic [WIDTH-1:0] muxOut;

`ifdef ARB_TIMEOUT_EN
   logic [7:0]       holdCnt_q;
   logic             timeout_q;
`else
   logic [7:0]       unusedMaxHold;
   assign unusedMaxHold = 8'(MAX_HOLD);
`endif

   // sel_q always names the current grantee while in GRANT, so it indexes its req/done lines.
   always_comb begin
      normalEnd   = bus.done[sel_q] | ~bus.req[sel_q];
`ifdef ARB_TIMEOUT_EN
      holdExpired = (holdCnt_q == 8'(MAX_HOLD - 1)) & ~normalEnd;
`else
      holdExpired = 1'b0;
`endif
      grantEnd    = (state_q == ARB_GRANT) & (normalEnd | holdExpired);
      ptr_d       = grantEnd ? sel_q + 2'd1 : ptr_q;
      arbExcl     = (state_q == ARB_GRANT) ? gnt_q : '0;
      pick        = rr_pick(bus.req, ptr_d, arbExcl);
      newGrant    = pick[SELW] & ((state_q == ARB_IDLE) | grantEnd);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ARB_IDLE;
         gnt_q     <= '0;
         sel_q     <= '0;
         ptr_q     <= '0;
`ifdef ARB_TIMEOUT_EN
         holdCnt_q <= '0;
         timeout_q <= 1'b0;
`endif
      end else begin
         ptr_q <= ptr_d;
`ifdef ARB_TIMEOUT_EN
         timeout_q <= grantEnd & holdExpired;
         if (newGrant) begin
            holdCnt_q <= '0;
         end else if (state_q == ARB_GRANT) begin
            holdCnt_q <= holdCnt_q + 8'd1;
         end
`endif
         case (state_q)
            ARB_IDLE: begin
               if (pick[SELW]) begin
                  state_q <= ARB_GRANT;
                  gnt_q   <= 4'b0001 << pick[SELW-1:0];
                  sel_q   <= pick[SELW-1:0];
               end
            end
            ARB_GRANT: begin
               // A finished grant hands straight over to the next pending requester when there is one.
               if (grantEnd) begin
                  if (pick[SELW]) begin
                     gnt_q <= 4'b0001 << pick[SELW-1:0];
                     sel_q <= pick[SELW-1:0];
                  end else begin
                     state_q <= ARB_IDLE;
                     gnt_q   <= '0;
                  end
               end
            end
         endcase
      end
   end

   yMux4to1 #(.WIDTH(WIDTH)) dataMux (
      .d0_i  (bus.d0),
      .d1_i  (bus.d1),
      .d2_i  (bus.d2),
      .d3_i  (bus.d3),
      .sel_i (sel_q),
      .z_o   (muxOut)
   );

   assign bus.out_data  = muxOut;
   assign bus.gnt       = gnt_q;
   assign bus.sel       = sel_q;
   assign bus.busy      = (state_q == ARB_GRANT);
   assign bus.out_valid = |(gnt_q & bus.req);
`ifdef ARB_TIMEOUT_EN
   assign bus.timeout   = timeout_q;
`else
   assign bus.timeout   = 1'b0;
`endif

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Self-checking bench for mux4_rr_arbiter: vector table, hand-written corner sequences and
// randomized traffic against a behavioural model; watchdog sequence runs when ARB_TIMEOUT_EN is defined.
module tb_mux4_rr_arbiter;

`ifdef ARB_TIMEOUT_EN
   localparam int MH = 4;
`else
   localparam int MH = 16;
`endif

   logic clk = 1'b0;
   logic rst;

   mux4_rr_arbiter_if #(.WIDTH(32)) bus();

   mux4_rr_arbiter #(.WIDTH(32), .MAX_HOLD(MH)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int          checks = 0;
   int          errors = 0;
   logic [31:0] tD [4];

   // Model state: index currently granted (-1 when idle), rotating priority start, last select.
   int   mGrant;
   int   mPtr;
   int   mSel;
   int   mHold;
   logic mTimeout;

   typedef struct {
      logic [3:0] req;
      logic [3:0] done;
      logic [3:0] expGnt;
      logic [1:0] expSel;
      logic       expBusy;
   } vec_t;

   vec_t vecs [11];

   task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic modelReset();
      mGrant   = -1;
      mPtr     = 0;
      mSel     = 0;
      mHold    = 0;
      mTimeout = 1'b0;
   endtask

   // Applies one clock edge of the arbitration rules to the model.
   task automatic modelStep();
      int  g;
      int  idx;
      bit  ended;
      mTimeout = 1'b0;
      if (mGrant < 0) begin
         for (int k = 0; k < 4; k++) begin
            idx = (mPtr + k) % 4;
            if (mGrant < 0 && bus.req[idx]) begin
               mGrant = idx;
               mSel   = idx;
               mHold  = 0;
            end
         end
      end else begin
         g     = mGrant;
         ended = bus.done[g] || !bus.req[g];
`ifdef ARB_TIMEOUT_EN
         if (!ended && mHold == MH - 1) begin
            ended    = 1'b1;
            mTimeout = 1'b1;
         end
`endif
         if (ended) begin
            mPtr   = (g + 1) % 4;
            mGrant = -1;
            for (int k = 0; k < 3; k++) begin
               idx = (g + 1 + k) % 4;
               if (mGrant < 0 && bus.req[idx]) begin
                  mGrant = idx;
                  mSel   = idx;
                  mHold  = 0;
               end
            end
         end else begin
            mHold++;
         end
      end
   endtask

   task automatic applyStimulus(input logic [3:0] r, input logic [3:0] dn);
      bus.req  = r;
      bus.done = dn;
      for (int i = 0; i < 4; i++) tD[i] = $urandom;
      bus.d0 = tD[0];
      bus.d1 = tD[1];
      bus.d2 = tD[2];
      bus.d3 = tD[3];
   endtask

   task automatic tick();
      @(posedge clk);
      if (!rst) modelStep();
      #2;
   endtask

   task automatic doReset();
      rst = 1'b1;
      applyStimulus(4'b0000, 4'b0000);
      modelReset();
      repeat (2) @(posedge clk);
      #2;
      rst = 1'b0;
   endtask

   task automatic checkOutput(input string name);
      logic [3:0] expGnt;
      logic       expValid;
      expGnt   = (mGrant < 0) ? 4'b0000 : 4'(1 << mGrant);
      expValid = (mGrant >= 0) && bus.req[mGrant];
      checkVal({name, ".gnt"},       32'(bus.gnt),       32'(expGnt));
      checkVal({name, ".sel"},       32'(bus.sel),       32'(mSel));
      checkVal({name, ".busy"},      32'(bus.busy),      32'(mGrant >= 0));
      checkVal({name, ".out_valid"}, 32'(bus.out_valid), 32'(expValid));
      checkVal({name, ".out_data"},  bus.out_data,       tD[mSel]);
      checkVal({name, ".timeout"},   32'(bus.timeout),   32'(mTimeout));
      checkVal({name, ".onehot"},    32'($onehot0(bus.gnt)), 32'd1);
   endtask

   initial begin
      logic [3:0] r;
      logic [3:0] dn;
      int         exp;

      vecs[0]  = '{4'b0110, 4'b0000, 4'b0010, 2'd1, 1'b1};
      vecs[1]  = '{4'b0110, 4'b0010, 4'b0100, 2'd2, 1'b1};
      vecs[2]  = '{4'b0100, 4'b0000, 4'b0100, 2'd2, 1'b1};
      vecs[3]  = '{4'b0100, 4'b0001, 4'b0100, 2'd2, 1'b1};
      vecs[4]  = '{4'b1000, 4'b0000, 4'b1000, 2'd3, 1'b1};
      vecs[5]  = '{4'b0000, 4'b0000, 4'b0000, 2'd3, 1'b0};
      vecs[6]  = '{4'b1001, 4'b0000, 4'b0001, 2'd0, 1'b1};
      vecs[7]  = '{4'b1001, 4'b0100, 4'b0001, 2'd0, 1'b1};
      vecs[8]  = '{4'b1000, 4'b0001, 4'b1000, 2'd3, 1'b1};
      vecs[9]  = '{4'b1000, 4'b1000, 4'b0000, 2'd3, 1'b0};
      vecs[10] = '{4'b0000, 4'b0000, 4'b0000, 2'd3, 1'b0};

      doReset();
      checkVal("reset.gnt",       32'(bus.gnt),       32'd0);
      checkVal("reset.sel",       32'(bus.sel),       32'd0);
      checkVal("reset.busy",      32'(bus.busy),      32'd0);
      checkVal("reset.out_valid", 32'(bus.out_valid), 32'd0);
      checkVal("reset.timeout",   32'(bus.timeout),   32'd0);

      // Vector table: handover without idle, ignored foreign done, abandon, same-cycle done+drop.
      for (int i = 0; i < 11; i++) begin
         applyStimulus(vecs[i].req, vecs[i].done);
         tick();
         checkVal($sformatf("vec%0d.gnt", i),  32'(bus.gnt),  32'(vecs[i].expGnt));
         checkVal($sformatf("vec%0d.sel", i),  32'(bus.sel),  32'(vecs[i].expSel));
         checkVal($sformatf("vec%0d.busy", i), 32'(bus.busy), 32'(vecs[i].expBusy));
         checkVal($sformatf("vec%0d.out_valid", i), 32'(bus.out_valid),
                  32'((vecs[i].expGnt & vecs[i].req) != 4'b0000));
         checkVal($sformatf("vec%0d.out_data", i), bus.out_data, tD[vecs[i].expSel]);
      end

      // Full load: grant order must rotate 0,1,2,3,0.
      doReset();
      applyStimulus(4'b1111, 4'b0000);
      tick();
      for (int n = 0; n < 5; n++) begin
         exp = n % 4;
         checkVal($sformatf("rr%0d.gnt", n), 32'(bus.gnt), 32'(1 << exp));
         applyStimulus(4'b1111, 4'b0000);
         tick();
         checkVal($sformatf("rr%0d.hold", n), 32'(bus.gnt), 32'(1 << exp));
         applyStimulus(4'b1111, 4'(1 << exp));
         tick();
         checkVal($sformatf("rr%0d.onehot", n), 32'($onehot0(bus.gnt)), 32'd1);
      end

      // Asynchronous reset in the middle of a grant clears outputs before the next edge.
      doReset();
      applyStimulus(4'b0100, 4'b0000);
      tick();
      checkVal("midrst.pre_gnt", 32'(bus.gnt), 32'b0100);
      checkVal("midrst.pre_sel", 32'(bus.sel), 32'd2);
      #1 rst = 1'b1;
      #1;
      checkVal("midrst.gnt",       32'(bus.gnt),       32'd0);
      checkVal("midrst.sel",       32'(bus.sel),       32'd0);
      checkVal("midrst.busy",      32'(bus.busy),      32'd0);
      checkVal("midrst.out_valid", 32'(bus.out_valid), 32'd0);

`ifdef ARB_TIMEOUT_EN
      // Watchdog: a grant held without done is reclaimed on its fourth cycle.
      doReset();
      applyStimulus(4'b0001, 4'b0000);
      tick();
      checkVal("wd.grant", 32'(bus.gnt), 32'b0001);
      for (int k = 0; k < 3; k++) begin
         applyStimulus(4'b0001, 4'b0000);
         tick();
         checkVal($sformatf("wd.held%0d", k), 32'(bus.gnt), 32'b0001);
         checkVal($sformatf("wd.quiet%0d", k), 32'(bus.timeout), 32'd0);
      end
      applyStimulus(4'b0001, 4'b0000);
      tick();
      checkVal("wd.release_gnt", 32'(bus.gnt), 32'd0);
      checkVal("wd.release_to",  32'(bus.timeout), 32'd1);
      applyStimulus(4'b0001, 4'b0000);
      tick();
      checkVal("wd.regrant_gnt", 32'(bus.gnt), 32'b0001);
      checkVal("wd.regrant_to",  32'(bus.timeout), 32'd0);
      for (int k = 0; k < 3; k++) begin
         applyStimulus(4'b0011, 4'b0000);
         tick();
         checkVal($sformatf("wd.held2_%0d", k), 32'(bus.gnt), 32'b0001);
      end
      applyStimulus(4'b0011, 4'b0000);
      tick();
      checkVal("wd.move_gnt",  32'(bus.gnt), 32'b0010);
      checkVal("wd.move_to",   32'(bus.timeout), 32'd1);
      checkVal("wd.move_busy", 32'(bus.busy), 32'd1);
      applyStimulus(4'b0011, 4'b0000);
      tick();
      checkVal("wd.pulse_end", 32'(bus.timeout), 32'd0);
`endif

      // Randomized traffic against the behavioural model.
      doReset();
      for (int c = 0; c < 400; c++) begin
         r = 4'($urandom_range(0, 15));
         if (mGrant >= 0 && $urandom_range(0, 3) != 0) r[mGrant] = 1'b1;
         dn = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000;
         if (mGrant >= 0 && $urandom_range(0, 3) == 0) dn[mGrant] = 1'b1;
         applyStimulus(r, dn);
         tick();
         checkOutput($sformatf("rand%0d", c));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
